ram_sp_clr: RTL and testbench

- Parametrised single-port synchronous RAM, generalising the team's 32x32 lab RAM.
- Adds per-byte write enables and a read-valid strobe.
- Adds a reset-triggered hardware clear sequencer that replaces simulation-only zero initialisation.
- Sits between a datapath/controller and storage; the host must wait for busy=0 before issuing accesses.

---
 rtl/ram_sp_clr.sv | 127 ++++++++++++
 tb/tb_ram_sp_clr.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with per-byte write enables and a hardware clear sequencer.
// Latency: read data 1 cycle after the read edge (2 cycles with RAM_SP_CLR_OUT_REG_EN).
// Backpressure: none; busy=1 while clearing, and accesses issued then are dropped.
//
// Optional feature macro: RAM_SP_CLR_OUT_REG_EN adds an output pipeline stage.
//   When it is defined, dout and dout_valid move through the extra stage together.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; it restarts the clear sequence
//   cen        chip enable (1 = access this cycle)
//   wen        1 = write, 0 = read (qualified by cen)
//   be         byte enables for writes; be[k] covers din[8k+7:8k]
//   addr       word address; out-of-range writes are dropped and reads return 0
//   din        write data
//   dout       registered read data; 0 on any cycle that is not a read
//   dout_valid high for exactly the cycle dout carries read data
//   busy       high while the clear sequence runs

module ram_sp_clr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;

  // One-hot pair with a default arm, so any corrupted state falls back to CLEAR.
  localparam logic [1:0] CLEAR = 2'b01;
  localparam logic [1:0] READY = 2'b10;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range;
  logic [DATA_W-1:0] rd_dat;
  logic              rd_vld;

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign busy     = (state != READY);

  // Control and first read stage. The reset edge leaves memory alone;
  // zeroing happens one word per cycle once reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      rd_dat   <= '0;
      rd_vld   <= 1'b0;
    end else begin
      rd_dat <= '0;
      rd_vld <= 1'b0;
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_A) begin
            state <= READY;
          end
        end
        READY: begin
          if (cen && !wen) begin
            rd_dat <= in_range ? mem[addr] : '0;
            rd_vld <= 1'b1;
          end
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
        end
      endcase
    end
  end

  // Storage array: kept free of reset so it can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (state == READY && cen && wen && in_range) begin
        for (int k = 0; k < BE_W; k++) begin
          if (be[k]) begin
            mem[addr][8*k +: 8] <= din[8*k +: 8];
          end
        end
      end
    end
  end

`ifdef RAM_SP_CLR_OUT_REG_EN
  // Second stage: stage one always loads zero or valid data, so a read
  // already in flight drains here even if cen drops behind it.
  logic [DATA_W-1:0] pipe_dat;
  logic              pipe_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_dat <= '0;
      pipe_vld <= 1'b0;
    end else begin
      pipe_dat <= rd_dat;
      pipe_vld <= rd_vld;
    end
  end

  assign dout       = pipe_dat;
  assign dout_valid = pipe_vld;
`else
  assign dout       = rd_dat;
  assign dout_valid = rd_vld;
`endif

endmodule

// File: tb/tb_ram_sp_clr.sv
module tb_ram_sp_clr;

`ifdef RAM_SP_CLR_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  // default-parameter instance
  logic        cen, wen;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] din, dout;
  logic        dout_valid, busy;
  // small instance: 16-bit words, 4-bit address, 10 entries
  logic        m_cen, m_wen;
  logic [1:0]  m_be;
  logic [3:0]  m_addr;
  logic [15:0] m_din, m_dout;
  logic        m_dout_valid, m_busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ram_sp_clr dut (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .be(be), .addr(addr),
    .din(din), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  ram_sp_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(10)) dut_s (
    .clk(clk), .rst(rst), .cen(m_cen), .wen(m_wen), .be(m_be), .addr(m_addr),
    .din(m_din), .dout(m_dout), .dout_valid(m_dout_valid), .busy(m_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply a write to the large instance for one edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    cen = 1'b1; wen = 1'b1; addr = a; din = d; be = b;
    cyc();
    cen = 1'b0;
  endtask

  // Issue a read, wait the read latency, check data and strobe.
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cen = 1'b1; wen = 1'b0; addr = a;
    cyc();
    cen = 1'b0;
    repeat (LAT - 1) cyc();
    chk({tag, ".dat"}, dout, exp);
    chk({tag, ".vld"}, {31'b0, dout_valid}, 32'd1);
  endtask

  task automatic m_wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    m_cen = 1'b1; m_wen = 1'b1; m_addr = a; m_din = d; m_be = b;
    cyc();
    m_cen = 1'b0;
  endtask

  task automatic m_rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
    m_cen = 1'b1; m_wen = 1'b0; m_addr = a;
    cyc();
    m_cen = 1'b0;
    repeat (LAT - 1) cyc();
    chk({tag, ".dat"}, {16'b0, m_dout}, {16'b0, exp});
    chk({tag, ".vld"}, {31'b0, m_dout_valid}, 32'd1);
  endtask

  // Count busy cycles of both instances after reset release; bounded.
  task automatic busy_count(input string tag, input int exp_big, input int exp_small);
    int n1 = 0;
    int n2 = 0;
    int guard = 0;
    while ((busy || m_busy) && guard < 200) begin
      if (busy) n1++;
      if (m_busy) n2++;
      cyc();
      guard++;
    end
    chk({tag, ".timeout"}, {31'b0, guard >= 200}, 32'd0);
    chk({tag, ".busy32"}, n1, exp_big);
    chk({tag, ".busy10"}, n2, exp_small);
  endtask

  initial begin
    rst = 1'b1;
    cen = 1'b0; wen = 1'b0; be = '0; addr = '0; din = '0;
    m_cen = 1'b0; m_wen = 1'b0; m_be = '0; m_addr = '0; m_din = '0;

    // Reset for two cycles, then check the reset outputs.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.dout", dout, 32'h0);
    chk("rst.vld", {31'b0, dout_valid}, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;

    // Clear timing, with a write to addr 5 attempted throughout the clear.
    cen = 1'b1; wen = 1'b1; addr = 5'd5; din = 32'h12345678; be = 4'hF;
    chk("clr.vld", {31'b0, dout_valid}, 32'd0);
    busy_count("clr1", 32, 10);
    cen = 1'b0;
    rd("lockout", 5'd5, 32'h0);
    for (int a = 0; a < 32; a++) rd($sformatf("clr.a%0d", a), 5'(a), 32'h0);

    // Byte-enable merge.
    wr(5'd3, 32'hAABBCCDD, 4'b1111);
    wr(5'd3, 32'h11223344, 4'b0101);
    rd("be.merge", 5'd3, 32'hAA22CC44);
    // be=0 write leaves data intact and is a write cycle.
    wr(5'd3, 32'hFFFFFFFF, 4'b0000);
    chk("be0.dout", dout, 32'h0);
    rd("be0.keep", 5'd3, 32'hAA22CC44);

    // Write cycle zeroes dout; write then read next cycle; single-cycle valid.
    cen = 1'b1; wen = 1'b1; addr = 5'd31; din = 32'hDEADBEEF; be = 4'hF;
    cyc();
    if (LAT == 2) cyc();
    chk("wcyc.dout", dout, 32'h0);
    chk("wcyc.vld", {31'b0, dout_valid}, 32'd0);
    rd("b2b.a31", 5'd31, 32'hDEADBEEF);
    addr = 5'd31;
    cyc();
    chk("vld.once", {31'b0, dout_valid}, 32'd0);
    chk("dis.dout", dout, 32'h0);

    // Reset mid-operation: fill, pulse in READY, pulse again at clear cycle 10.
    for (int a = 0; a < 32; a++) wr(5'(a), 32'h5A000000 | (a + 1), 4'hF);
    rd("fill.a7", 5'd7, 32'h5A000008);
    rst = 1'b1;
    cyc();
    chk("mid.busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    repeat (10) cyc();
    chk("mid.stillbusy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    busy_count("clr2", 32, 10);
    for (int a = 0; a < 32; a++) rd($sformatf("reclr.a%0d", a), 5'(a), 32'h0);

    // Small instance: byte enables, out-of-range write and read.
    m_wr(4'd2, 16'h1234, 2'b10);
    m_wr(4'd12, 16'hBEEF, 2'b11);
    m_rd("s.a2", 4'd2, 16'h1200);
    m_rd("s.a4", 4'd4, 16'h0000);
    m_rd("s.a12", 4'd12, 16'h0000);
    m_rd("s.a9", 4'd9, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
